// File: rtl/cpu_types_pkg.sv
// Shared types for the coherent L1 data cache.
// Covers the MSI line states, the frame layout and the controller states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    I = 2'b00,
    S = 2'b01,
    M = 2'b10
  } msi_t;

  typedef struct packed {
    msi_t        state;
    logic [29:0] tag;
    logic [31:0] data;
  } dcache_frame_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    FETCH = 3'd2,
    SNOOP = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } dcache_state_t;

  // The tag is stored right-aligned in 30 bits, so one frame layout works for any set count.
  function automatic logic [29:0] addr_tag(input logic [31:0] addr, input int unsigned idx_w);
    return 30'(addr >> (idx_w + 32'd2));
  endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// Direct-mapped frame storage for the data cache.
// It has one write port and two combinational read ports, one for the CPU and one for the snooper.
module dcache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16,
  parameter int IW   = $clog2(SETS)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          wen,
  input  logic [IW-1:0] widx,
  input  dcache_frame_t wframe,
  input  logic [IW-1:0] cidx,
  output dcache_frame_t cframe,
  input  logic [IW-1:0] sidx,
  output dcache_frame_t sframe
);

  dcache_frame_t frames_r [SETS];

  // Frame storage, cleared to Invalid on reset
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        frames_r[i] <= '0;
      end
    end else if (wen) begin
      frames_r[widx] <= wframe;
    end
  end

  assign cframe = frames_r[cidx];
  assign sframe = frames_r[sidx];

endmodule

// File: rtl/coherent_dcache.sv
// Direct-mapped write-back L1 data cache with MSI snooping.
// It supplies data cache-to-cache, and on halt it writes back every Modified line.
module coherent_dcache
  import cpu_types_pkg::*;
#(
  parameter int CPUID = 0,
  parameter int SETS  = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(SETS - 1);

  if (CPUID < 0 || SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_param_check
    $error("coherent_dcache: CPUID must be >= 0 and SETS a power of two >= 2");
  end

  dcache_state_t state_r, ret_r;
  logic          inv_seen_r, flushed_r;
  logic [IW-1:0] flush_idx_r;

  dcache_frame_t cfr_s, sfr_s, wframe_s;
  logic          wen_s;
  logic [IW-1:0] widx_s, cpu_idx_s, req_idx_s, snp_idx_s;
  logic [29:0]   req_tag_s;
  logic          req_s, hit_s, idle_hit_s, victim_dirty_s, snp_hit_s;

  assign req_idx_s = dmemaddr[IW+1:2];
  assign req_tag_s = addr_tag(dmemaddr, IW);
  assign snp_idx_s = ccsnoopaddr[IW+1:2];
  assign cpu_idx_s = (state_r == FLUSH) ? flush_idx_r : req_idx_s;

  assign req_s          = dmemREN | dmemWEN;
  // Only an M line accepts a write; writing an S line is an upgrade miss.
  assign hit_s          = (cfr_s.tag == req_tag_s) &&
                          (dmemWEN ? (cfr_s.state == M) : (cfr_s.state != I));
  assign idle_hit_s     = (state_r == IDLE) && !ccwait && req_s && hit_s;
  assign victim_dirty_s = (cfr_s.state == M) && (cfr_s.tag != req_tag_s);
  assign snp_hit_s      = (sfr_s.state != I) && (sfr_s.tag == addr_tag(ccsnoopaddr, IW));
  assign flushed        = flushed_r;

  dcache_frame_array #(.SETS(SETS), .IW(IW)) u_array (
    .CLK    (CLK),
    .nRST   (nRST),
    .wen    (wen_s),
    .widx   (widx_s),
    .wframe (wframe_s),
    .cidx   (cpu_idx_s),
    .cframe (cfr_s),
    .sidx   (snp_idx_s),
    .sframe (sfr_s)
  );

  // Controller state machine: miss handling, snoop service and the flush walk
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      ret_r       <= IDLE;
      inv_seen_r  <= 1'b0;
      flush_idx_r <= '0;
      flushed_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ccwait) begin
            state_r    <= SNOOP;
            ret_r      <= IDLE;
            inv_seen_r <= ccinv;
          end else if (req_s && !hit_s) begin
            state_r <= victim_dirty_s ? WB : FETCH;
          end else if (halt) begin
            state_r     <= FLUSH;
            flush_idx_r <= '0;
          end
        end
        WB: begin
          if (!dwait) state_r <= FETCH;
        end
        FETCH: begin
          if (ccwait) begin
            state_r    <= SNOOP;
            ret_r      <= IDLE;
            inv_seen_r <= ccinv;
          end else if (!dwait) begin
            state_r <= IDLE;
          end
        end
        SNOOP: begin
          if (ccwait) inv_seen_r <= inv_seen_r | ccinv;
          else        state_r    <= ret_r;
        end
        FLUSH: begin
          if (ccwait) begin
            state_r    <= SNOOP;
            ret_r      <= FLUSH;
            inv_seen_r <= ccinv;
          end else if (cfr_s.state != M || !dwait) begin
            if (flush_idx_r == LAST_IDX) begin
              state_r   <= DONE;
              flushed_r <= 1'b1;
            end else begin
              flush_idx_r <= flush_idx_r + IW'(1);
            end
          end
        end
        DONE: begin
          if (ccwait) begin
            state_r    <= SNOOP;
            ret_r      <= DONE;
            inv_seen_r <= ccinv;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Frame update: store hit, victim invalidate, fill, snoop downgrade and flush clean
  always_comb begin
    wen_s    = 1'b0;
    widx_s   = cpu_idx_s;
    wframe_s = cfr_s;
    case (state_r)
      IDLE: begin
        if (idle_hit_s && dmemWEN) begin
          wen_s         = 1'b1;
          wframe_s.data = dmemstore;
        end else begin
          wen_s = 1'b0;
        end
      end
      WB: begin
        if (!dwait) begin
          wen_s          = 1'b1;
          wframe_s.state = I;
        end else begin
          wen_s = 1'b0;
        end
      end
      FETCH: begin
        if (!ccwait && !dwait) begin
          wen_s         = 1'b1;
          wframe_s.tag  = req_tag_s;
          wframe_s.data = dload;
          if (dmemWEN) wframe_s.state = M;
          else         wframe_s.state = S;
        end else begin
          wen_s = 1'b0;
        end
      end
      SNOOP: begin
        widx_s   = snp_idx_s;
        wframe_s = sfr_s;
        if (!ccwait && snp_hit_s) begin
          wen_s = 1'b1;
          if (inv_seen_r || ccinv)  wframe_s.state = I;
          else if (sfr_s.state == M) wframe_s.state = S;
          else                       wframe_s.state = sfr_s.state;
        end else begin
          wen_s = 1'b0;
        end
      end
      FLUSH: begin
        if (!ccwait && cfr_s.state == M && !dwait) begin
          wen_s          = 1'b1;
          wframe_s.state = I;
        end else begin
          wen_s = 1'b0;
        end
      end
      default: wen_s = 1'b0;
    endcase
  end

  // Datapath response and bus/coherence output decode
  always_comb begin
    dhit     = 1'b0;
    dmemload = 32'h0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    case (state_r)
      IDLE: begin
        if (idle_hit_s) begin
          dhit     = 1'b1;
          dmemload = cfr_s.data;
        end else begin
          dhit = 1'b0;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {cfr_s.tag[TW-1:0], req_idx_s, 2'b00};
        dstore = cfr_s.data;
      end
      FETCH: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = dmemaddr;
      end
      SNOOP: begin
        if (snp_hit_s && sfr_s.state == M) begin
          cctrans = 1'b1;
          dWEN    = 1'b1;
          daddr   = ccsnoopaddr;
          dstore  = sfr_s.data;
        end else begin
          cctrans = 1'b0;
        end
      end
      FLUSH: begin
        if (cfr_s.state == M) begin
          dWEN   = 1'b1;
          daddr  = {cfr_s.tag[TW-1:0], flush_idx_r, 2'b00};
          dstore = cfr_s.data;
        end else begin
          dWEN = 1'b0;
        end
      end
      default: dhit = 1'b0;
    endcase
  end

endmodule
